// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin owner of the shared memory port (CPU vs loader) with
//            variable-latency wait, per-access timeout and ack/err response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  localparam logic [1:0]    C_IDLE     = 2'd0;
  localparam logic [1:0]    C_ACCESS   = 2'd1;
  localparam logic [1:0]    C_RESP     = 2'd2;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          sel;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sel         = 1'b0;

    case (state_q)
      C_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not own the port last time wins.
          sel         = (req0 && req1) ? ~last_gnt_q : req1;
          state_d     = C_ACCESS;
          last_gnt_d  = sel;
          cnt_d       = '0;
          gnt0_d      = ~sel;
          gnt1_d      = sel;
          mem_en_d    = 1'b1;
          mem_we_d    = sel ? we1    : we0;
          mem_addr_d  = sel ? addr1  : addr0;
          mem_wdata_d = sel ? wdata1 : wdata0;
        end
      end

      C_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ready) begin
          rdata_d  = mem_we_q ? '0 : mem_rdata;
          ack0_d   = gnt0_q;
          ack1_d   = gnt1_q;
          err0_d   = 1'b0;
          err1_d   = 1'b0;
          mem_en_d = 1'b0;
          state_d  = C_RESP;
        end else if (cnt_q == C_CNT_LAST) begin
          rdata_d  = '0;
          ack0_d   = gnt0_q;
          ack1_d   = gnt1_q;
          err0_d   = gnt0_q;
          err1_d   = gnt1_q;
          mem_en_d = 1'b0;
          state_d  = C_RESP;
        end
      end

      C_RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = C_IDLE;
      end

      default: begin
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        mem_en_d = 1'b0;
        state_d  = C_IDLE;
      end
    endcase

    busy_d = (state_d != C_IDLE);
  end

  // Reset abandons any access in flight; last_gnt=1 lets the CPU win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= C_IDLE;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
